// File: rtl/cpu_mem_responder.sv
// Serialises core icache/dcache requests onto one valid/ready backing-memory port, data first.
// Optional ICACHE_LAST_HIT_EN adds a one-entry last-fetch buffer that skips repeated fetches.
module cpu_mem_responder #(
  parameter int unsigned MEM_AW = 14,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       icache_addr,
  input  logic              icache_re,
  output logic [DWIDTH-1:0] icache_dout,
  input  logic [31:0]       dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [DWIDTH-1:0] dcache_din,
  output logic [DWIDTH-1:0] dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rnw,
  output logic [MEM_AW-1:0] mem_req_addr,
  output logic [DWIDTH-1:0] mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [DWIDTH-1:0] mem_resp_data
);

  typedef enum logic [2:0] {IDLE, D_REQ, D_RESP, I_REQ, I_RESP} state_e;

  localparam logic [DWIDTH-1:0] NOP_INSN = DWIDTH'(32'h0000_0013);

  state_e              state_q, state_d;
  logic                stall_q, stall_d;
  logic                i_pend_q, i_pend_d;
  logic                d_write_q, d_write_d;
  logic [MEM_AW-1:0]   i_addr_q, i_addr_d;
  logic                req_valid_q, req_valid_d;
  logic                req_rnw_q, req_rnw_d;
  logic [MEM_AW-1:0]   req_addr_q, req_addr_d;
  logic [DWIDTH-1:0]   req_data_q, req_data_d;
  logic [3:0]          req_mask_q, req_mask_d;
  logic [DWIDTH-1:0]   icache_dout_q, icache_dout_d;
  logic [DWIDTH-1:0]   dcache_dout_q, dcache_dout_d;

  logic [MEM_AW-1:0]   i_wa, d_wa, fetch_addr;
  logic                d_wr, d_acc, fetch_hit, start_fetch;
  logic                unused_addr_bits;

  assign i_wa  = icache_addr[MEM_AW+1:2];
  assign d_wa  = dcache_addr[MEM_AW+1:2];
  assign d_wr  = |dcache_we;
  assign d_acc = d_wr | dcache_re;

  assign unused_addr_bits = ^{icache_addr[31:MEM_AW+2], icache_addr[1:0],
                              dcache_addr[31:MEM_AW+2], dcache_addr[1:0]};

`ifdef ICACHE_LAST_HIT_EN
  // icache_dout_q doubles as the buffered instruction: it only changes on a completed fetch
  logic                buf_valid_q, buf_valid_d;
  logic [MEM_AW-1:0]   buf_addr_q, buf_addr_d;
  assign fetch_hit = buf_valid_q && (buf_addr_q == i_wa) && !d_acc;
`else
  assign fetch_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    i_pend_d      = i_pend_q;
    d_write_d     = d_write_q;
    i_addr_d      = i_addr_q;
    req_valid_d   = req_valid_q;
    req_rnw_d     = req_rnw_q;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    req_mask_d    = req_mask_q;
    icache_dout_d = icache_dout_q;
    dcache_dout_d = dcache_dout_q;
    fetch_addr    = i_addr_q;
    start_fetch   = 1'b0;
`ifdef ICACHE_LAST_HIT_EN
    buf_valid_d   = buf_valid_q;
    buf_addr_d    = buf_addr_q;
`endif

    case (state_q)
      IDLE: begin
        if (d_acc) begin
          state_d     = D_REQ;
          req_valid_d = 1'b1;
          req_rnw_d   = ~d_wr;
          req_addr_d  = d_wa;
          req_data_d  = dcache_din;
          req_mask_d  = d_wr ? dcache_we : 4'hF;
          d_write_d   = d_wr;
          i_pend_d    = icache_re;
          i_addr_d    = i_wa;
`ifdef ICACHE_LAST_HIT_EN
          if (d_wr && (d_wa == buf_addr_q)) buf_valid_d = 1'b0;
`endif
        end else if (icache_re && !fetch_hit) begin
          start_fetch = 1'b1;
          fetch_addr  = i_wa;
        end
      end
      D_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          if (!d_write_q)    state_d = D_RESP;
          else if (i_pend_q) start_fetch = 1'b1;
          else               state_d = IDLE;
        end
      end
      D_RESP: begin
        if (mem_resp_valid) begin
          dcache_dout_d = mem_resp_data;
          if (i_pend_q) start_fetch = 1'b1;
          else          state_d = IDLE;
        end
      end
      I_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = I_RESP;
        end
      end
      I_RESP: begin
        if (mem_resp_valid) begin
          icache_dout_d = mem_resp_data;
          state_d       = IDLE;
`ifdef ICACHE_LAST_HIT_EN
          buf_valid_d   = 1'b1;
          buf_addr_d    = req_addr_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Fetch issue is shared by IDLE, a finished write and a finished data read
    if (start_fetch) begin
      state_d     = I_REQ;
      req_valid_d = 1'b1;
      req_rnw_d   = 1'b1;
      req_addr_d  = fetch_addr;
      req_data_d  = '0;
      req_mask_d  = 4'hF;
      i_pend_d    = 1'b0;
    end

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      stall_q       <= 1'b0;
      i_pend_q      <= 1'b0;
      d_write_q     <= 1'b0;
      i_addr_q      <= '0;
      req_valid_q   <= 1'b0;
      req_rnw_q     <= 1'b1;
      req_addr_q    <= '0;
      req_data_q    <= '0;
      req_mask_q    <= 4'hF;
      icache_dout_q <= NOP_INSN;
      dcache_dout_q <= '0;
`ifdef ICACHE_LAST_HIT_EN
      buf_valid_q   <= 1'b0;
      buf_addr_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      stall_q       <= stall_d;
      i_pend_q      <= i_pend_d;
      d_write_q     <= d_write_d;
      i_addr_q      <= i_addr_d;
      req_valid_q   <= req_valid_d;
      req_rnw_q     <= req_rnw_d;
      req_addr_q    <= req_addr_d;
      req_data_q    <= req_data_d;
      req_mask_q    <= req_mask_d;
      icache_dout_q <= icache_dout_d;
      dcache_dout_q <= dcache_dout_d;
`ifdef ICACHE_LAST_HIT_EN
      buf_valid_q   <= buf_valid_d;
      buf_addr_q    <= buf_addr_d;
`endif
    end
  end

  assign stall         = stall_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_rnw   = req_rnw_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_data  = req_data_q;
  assign mem_req_mask  = req_mask_q;
  assign icache_dout   = icache_dout_q;
  assign dcache_dout   = dcache_dout_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder with a behavioural backing memory of programmable wait states.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] icache_addr, dcache_addr, dcache_din;
  logic        icache_re, dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] icache_dout, dcache_dout;
  logic        stall, mem_req_valid, mem_req_ready, mem_req_rnw;
  logic [13:0] mem_req_addr;
  logic [31:0] mem_req_data, mem_resp_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;

  logic        auto_mem;
  logic        a_ready, a_resp_valid, m_ready, m_resp_valid;
  logic [31:0] a_resp_data, m_resp_data;
  int          rdy_wait, rsp_wait;
  int          total = 0, bad = 0, unstable = 0;

  logic [31:0] mem_img [int];
  logic [13:0] lg_addr[$];
  logic        lg_rnw[$];
  logic [3:0]  lg_mask[$];
  logic [31:0] lg_data[$];

  assign mem_req_ready  = auto_mem ? a_ready : m_ready;
  assign mem_resp_valid = auto_mem ? a_resp_valid : m_resp_valid;
  assign mem_resp_data  = auto_mem ? a_resp_data : m_resp_data;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk(clk), .reset(reset),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  function automatic logic [31:0] mem_read(input logic [13:0] a);
    if (mem_img.exists(int'(a))) return mem_img[int'(a)];
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Backing memory: drives on negedges, logs each accepted request
  int          ph = 0, cnt = 0;
  logic        go;
  logic [13:0] s_addr;
  logic        s_rnw;
  logic [3:0]  s_mask;
  logic [31:0] s_data;
  always @(negedge clk) begin
    a_ready      = 1'b0;
    a_resp_valid = 1'b0;
    a_resp_data  = 32'h0;
    go           = 1'b0;
    if (!auto_mem || reset) begin
      ph = 0;
    end else if (ph == 2) begin
      if (cnt == 0) begin
        a_resp_valid = 1'b1;
        a_resp_data  = mem_read(s_addr);
        ph = 0;
      end else cnt--;
    end else if (ph == 1) begin
      if (mem_req_valid !== 1'b1 || mem_req_addr !== s_addr || mem_req_rnw !== s_rnw ||
          mem_req_mask !== s_mask || mem_req_data !== s_data) unstable++;
      go = 1'b1;
    end else if (mem_req_valid === 1'b1) begin
      s_addr = mem_req_addr; s_rnw = mem_req_rnw; s_mask = mem_req_mask; s_data = mem_req_data;
      cnt = rdy_wait;
      ph  = 1;
      go  = 1'b1;
    end
    if (go) begin
      if (cnt == 0) begin
        a_ready = 1'b1;
        lg_addr.push_back(s_addr); lg_rnw.push_back(s_rnw);
        lg_mask.push_back(s_mask); lg_data.push_back(s_data);
        if (s_rnw) begin ph = 2; cnt = rsp_wait; end
        else ph = 0;
      end else cnt--;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic ire, input logic [31:0] ia, input logic dre,
                        input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dd,
                        output int ns);
    @(negedge clk);
    icache_re = ire; icache_addr = ia;
    dcache_re = dre; dcache_we = dwe; dcache_addr = da; dcache_din = dd;
    @(posedge clk);
    ns = 0;
    @(negedge clk);
    while (stall === 1'b1 && ns < 500) begin
      ns++;
      @(negedge clk);
    end
    if (ns >= 500) check("stall_bound", 32'(stall), 32'h0);
    icache_re = 1'b0; dcache_re = 1'b0; dcache_we = 4'h0;
  endtask

  int ns, n0;

  initial begin
    reset = 1'b1; auto_mem = 1'b1; rdy_wait = 0; rsp_wait = 0;
    m_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = 32'h0;
    icache_re = 1'b0; icache_addr = 32'h0; dcache_re = 1'b0; dcache_we = 4'h0;
    dcache_addr = 32'h0; dcache_din = 32'h0;
    mem_img[32'h800] = 32'h0050_0093;
    mem_img[32'h401] = 32'h1111_2222;
    mem_img[32'h801] = 32'h3333_4444;
    mem_img[32'hC02] = 32'h0BAD_C0DE;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_valid", 32'(mem_req_valid), 32'h0);
    check("rst_idout", icache_dout, 32'h0000_0013);
    check("rst_ddout", dcache_dout, 32'h0);
    reset = 1'b0;

    // fetch only, resp after 3 wait cycles
    rsp_wait = 3; n0 = lg_addr.size();
    access(1'b1, 32'h0000_2000, 1'b0, 4'h0, 32'h0, 32'h0, ns);
    check("f_stall", 32'(ns), 32'd5);
    check("f_nreq", 32'(lg_addr.size() - n0), 32'd1);
    check("f_addr", 32'(lg_addr[n0]), 32'h800);
    check("f_rnw", 32'(lg_rnw[n0]), 32'h1);
    check("f_dout", icache_dout, 32'h0050_0093);

    // single read at zero wait, low address bits ignored
    rsp_wait = 0; n0 = lg_addr.size();
    access(1'b0, 32'h0, 1'b1, 4'h0, 32'hABCD_1017, 32'h0, ns);
    check("rd_stall", 32'(ns), 32'd2);
    check("rd_addr", 32'(lg_addr[n0]), 32'h405);
    check("rd_mask", 32'(lg_mask[n0]), 32'hF);
    check("rd_dout", dcache_dout, 32'hA500_0405);

    // simultaneous read + fetch: data first
    n0 = lg_addr.size();
    access(1'b1, 32'h0000_2004, 1'b1, 4'h0, 32'h0000_1004, 32'h0, ns);
    check("sim_stall", 32'(ns), 32'd4);
    check("sim_nreq", 32'(lg_addr.size() - n0), 32'd2);
    check("sim_addr0", 32'(lg_addr[n0]), 32'h401);
    check("sim_addr1", 32'(lg_addr[n0+1]), 32'h801);
    check("sim_ddout", dcache_dout, 32'h1111_2222);
    check("sim_idout", icache_dout, 32'h3333_4444);

    // write with ready held low 4 cycles
    rdy_wait = 4; n0 = lg_addr.size(); unstable = 0;
    access(1'b0, 32'h0, 1'b0, 4'b0011, 32'h0000_1008, 32'h0000_BEEF, ns);
    check("wr_stall", 32'(ns), 32'd5);
    check("wr_stable", 32'(unstable), 32'd0);
    check("wr_addr", 32'(lg_addr[n0]), 32'h402);
    check("wr_rnw", 32'(lg_rnw[n0]), 32'h0);
    check("wr_mask", 32'(lg_mask[n0]), 32'h3);
    check("wr_data", lg_data[n0], 32'h0000_BEEF);
    check("wr_ddout", dcache_dout, 32'h1111_2222);

    // we and re together -> write
    rdy_wait = 0; n0 = lg_addr.size();
    access(1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_100C, 32'hCAFE_F00D, ns);
    check("wre_stall", 32'(ns), 32'd1);
    check("wre_rnw", 32'(lg_rnw[n0]), 32'h0);
    check("wre_mask", 32'(lg_mask[n0]), 32'hF);
    check("wre_ddout", dcache_dout, 32'h1111_2222);

    // spurious response in IDLE
    auto_mem = 1'b0;
    @(negedge clk); m_resp_valid = 1'b1; m_resp_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    m_resp_valid = 1'b0;
    @(negedge clk);
    check("sp_ddout", dcache_dout, 32'h1111_2222);
    check("sp_idout", icache_dout, 32'h3333_4444);
    check("sp_stall", 32'(stall), 32'h0);
    auto_mem = 1'b1;

    // high address bits ignored
    n0 = lg_addr.size();
    access(1'b1, 32'hFFFF_3008, 1'b0, 4'h0, 32'h0, 32'h0, ns);
    check("hi_addr", 32'(lg_addr[n0]), 32'hC02);
    check("hi_dout", icache_dout, 32'h0BAD_C0DE);

    // repeated fetch, then store to the same word and fetch again
    access(1'b1, 32'h0000_2000, 1'b0, 4'h0, 32'h0, 32'h0, ns);
    check("lh_miss1", 32'(ns), 32'd2);
    n0 = lg_addr.size();
    access(1'b1, 32'h0000_2000, 1'b0, 4'h0, 32'h0, 32'h0, ns);
`ifdef ICACHE_LAST_HIT_EN
    check("lh_hit_stall", 32'(ns), 32'd0);
    check("lh_hit_nreq", 32'(lg_addr.size() - n0), 32'd0);
`else
    check("lh_nohit_stall", 32'(ns), 32'd2);
    check("lh_nohit_nreq", 32'(lg_addr.size() - n0), 32'd1);
`endif
    check("lh_dout", icache_dout, 32'h0050_0093);
    access(1'b0, 32'h0, 1'b0, 4'hF, 32'h0000_2000, 32'h1234_5678, ns);
    n0 = lg_addr.size();
    access(1'b1, 32'h0000_2000, 1'b0, 4'h0, 32'h0, 32'h0, ns);
    check("lh_inv_stall", 32'(ns), 32'd2);
    check("lh_inv_nreq", 32'(lg_addr.size() - n0), 32'd1);

    // async reset during D_REQ and D_RESP, late response ignored
    auto_mem = 1'b0;
    @(negedge clk); dcache_re = 1'b1; dcache_addr = 32'h0000_1010;
    @(negedge clk);
    check("rq_valid", 32'(mem_req_valid), 32'h1);
    #2 reset = 1'b1;
    #1 check("rq_valid_drop", 32'(mem_req_valid), 32'h0);
    check("rq_stall_drop", 32'(stall), 32'h0);
    dcache_re = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); dcache_re = 1'b1;
    @(negedge clk); m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0;
    check("rp_stall", 32'(stall), 32'h1);
    #2 reset = 1'b1;
    #1 check("rp_stall_drop", 32'(stall), 32'h0);
    check("rp_valid_drop", 32'(mem_req_valid), 32'h0);
    dcache_re = 1'b0;
    @(negedge clk); reset = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'hBADB_AD00;
    @(negedge clk); m_resp_valid = 1'b0;
    @(negedge clk);
    check("late_ddout", dcache_dout, 32'h0);
    check("late_idout", icache_dout, 32'h0000_0013);
    check("late_stall", 32'(stall), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
